// File: rtl/game_flow_controller.sv
// game_flow_controller: Frogger game sequencer (idle/running/death/level pause/game over).
// Owns the lives counter, the frog-respawn and car-direction reload strobes and the
// blink mask applied to the lives LEDs while dying or after the game has ended.
module game_flow_controller #(
    parameter int NUM_LIVES      = 4,
    parameter int C_DEATH_FRAMES = 60,
    parameter int C_LEVEL_FRAMES = 30,
    parameter int C_BLINK_FRAMES = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Has_Collided,
    input  logic                 i_Level_Up,
    input  logic                 i_Frame_Tick,
    output logic                 o_Game_Active,
    output logic                 o_Frog_Reset,
    output logic                 o_Reverse_Load,
    output logic [NUM_LIVES-1:0] o_Lives,
    output logic                 o_Game_Over,
    output logic [2:0]           o_State
);

    localparam int MAX_FRAMES = (C_DEATH_FRAMES > C_LEVEL_FRAMES) ? C_DEATH_FRAMES : C_LEVEL_FRAMES;
    localparam int FW         = $clog2(MAX_FRAMES + 1);
    localparam int BW         = $clog2(C_BLINK_FRAMES + 1);

    localparam logic [FW-1:0] DEATH_LAST = FW'(C_DEATH_FRAMES - 1);
    localparam logic [FW-1:0] LEVEL_LAST = FW'(C_LEVEL_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(C_BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RUNNING     = 3'd1,
        DEATH       = 3'd2,
        LEVEL_PAUSE = 3'd3,
        GAME_OVER   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LIVES-1:0]   lives_q, lives_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [BW-1:0]          blink_q, blink_d;
    logic                   phase_q, phase_d;
    logic                   start_q;
    // Set until the first start of a game; gates the direction reload out of IDLE.
    logic                   fresh_q, fresh_d;
    logic                   frog_reset_q, frog_reset_d;
    logic                   rev_load_q, rev_load_d;

    logic                   start_rise;
    logic [FW-1:0]          frame_inc;
    logic                   blinking;

    assign start_rise = i_Start & ~start_q;
    // Saturating increment: the frame counter must never wrap back to zero.
    assign frame_inc  = (frame_q == {FW{1'b1}}) ? frame_q : frame_q + 1'b1;
    assign blinking   = (state_q == DEATH) || (state_q == GAME_OVER);

    // State, counters and strobe registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            lives_q      <= '1;
            frame_q      <= '0;
            blink_q      <= '0;
            phase_q      <= 1'b1;
            start_q      <= 1'b0;
            fresh_q      <= 1'b1;
            frog_reset_q <= 1'b0;
            rev_load_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            start_q      <= i_Start;
            fresh_q      <= fresh_d;
            frog_reset_q <= frog_reset_d;
            rev_load_q   <= rev_load_d;
        end
    end

    // Next-state logic: game sequencing, lives bookkeeping and strobe requests.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        frame_d      = frame_q;
        fresh_d      = fresh_q;
        frog_reset_d = 1'b0;
        rev_load_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d    = RUNNING;
                    fresh_d    = 1'b0;
                    rev_load_d = fresh_q && (lives_q == {NUM_LIVES{1'b1}});
                end
            end
            RUNNING: begin
                // Collision takes priority over a simultaneous level-up.
                if (i_Has_Collided) begin
                    state_d = DEATH;
                    lives_d = lives_q >> 1;
                    frame_d = '0;
                end else if (i_Level_Up) begin
                    state_d    = LEVEL_PAUSE;
                    rev_load_d = 1'b1;
                    frame_d    = '0;
                end
            end
            DEATH: begin
                if (i_Frame_Tick) begin
                    frame_d = frame_inc;
                    if (frame_q == DEATH_LAST) begin
                        if (lives_q == '0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d      = IDLE;
                            frog_reset_d = 1'b1;
                        end
                    end
                end
            end
            LEVEL_PAUSE: begin
                if (i_Frame_Tick) begin
                    frame_d = frame_inc;
                    if (frame_q == LEVEL_LAST) begin
                        state_d      = RUNNING;
                        frog_reset_d = 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    state_d      = IDLE;
                    lives_d      = '1;
                    frog_reset_d = 1'b1;
                    rev_load_d   = 1'b1;
                    fresh_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink generator: runs only while dying or game over, otherwise parked at phase on.
    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        if (blinking) begin
            if (i_Frame_Tick) begin
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
        end else begin
            blink_d = '0;
            phase_d = 1'b1;
        end
    end

    // Output decode; an empty lives register flashes all LEDs once the game is over.
    always_comb begin
        o_Lives = lives_q;
        if (state_q == DEATH) begin
            o_Lives = lives_q & {NUM_LIVES{phase_q}};
        end else if (state_q == GAME_OVER) begin
            o_Lives = ((lives_q == '0) ? {NUM_LIVES{1'b1}} : lives_q) & {NUM_LIVES{phase_q}};
        end
    end

    assign o_Game_Active  = (state_q == RUNNING);
    assign o_Game_Over    = (state_q == GAME_OVER);
    assign o_State        = state_q;
    assign o_Frog_Reset   = frog_reset_q;
    assign o_Reverse_Load = rev_load_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed walk through the game flow followed by a randomized
// run, all compared against a lives-count / tick-count reference model of the game rules.
module tb_game_flow_controller;

    localparam int NL = 4;
    localparam int DF = 60;
    localparam int LF = 30;
    localparam int BF = 8;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b1;
    logic          i_Start = 1'b0;
    logic          i_Has_Collided = 1'b0;
    logic          i_Level_Up = 1'b0;
    logic          i_Frame_Tick = 1'b0;
    logic          o_Game_Active;
    logic          o_Frog_Reset;
    logic          o_Reverse_Load;
    logic [NL-1:0] o_Lives;
    logic          o_Game_Over;
    logic [2:0]    o_State;

    game_flow_controller #(
        .NUM_LIVES(NL), .C_DEATH_FRAMES(DF), .C_LEVEL_FRAMES(LF), .C_BLINK_FRAMES(BF)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Has_Collided(i_Has_Collided),
        .i_Level_Up(i_Level_Up), .i_Frame_Tick(i_Frame_Tick), .o_Game_Active(o_Game_Active),
        .o_Frog_Reset(o_Frog_Reset), .o_Reverse_Load(o_Reverse_Load), .o_Lives(o_Lives),
        .o_Game_Over(o_Game_Over), .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    string step     = "reset";

    // Reference model: game phase by its spec number, lives as a count, ticks as counts.
    int m_st;        // 0 idle, 1 running, 2 death, 3 level pause, 4 game over
    int m_lives;
    int m_frames;    // ticks seen in the current death / pause
    int m_bticks;    // ticks seen since entering the blinking phases
    bit m_fresh;
    bit m_prev_start;
    bit m_fr, m_rl;

    task automatic model_reset();
        m_st = 0; m_lives = NL; m_frames = 0; m_bticks = 0;
        m_fresh = 1'b1; m_prev_start = 1'b0; m_fr = 1'b0; m_rl = 1'b0;
    endtask

    task automatic model_step(bit s, bit c, bit l, bit t);
        bit rise;
        int ns;
        rise = s && !m_prev_start;
        m_prev_start = s;
        m_fr = 1'b0;
        m_rl = 1'b0;
        ns = m_st;
        if (m_st == 2 || m_st == 4) begin
            if (t) m_bticks++;
        end else begin
            m_bticks = 0;
        end
        if (m_st == 0) begin
            if (rise) begin
                ns = 1;
                m_rl = m_fresh && (m_lives == NL);
                m_fresh = 1'b0;
            end
        end else if (m_st == 1) begin
            if (c) begin
                ns = 2; m_lives--; m_frames = 0;
            end else if (l) begin
                ns = 3; m_rl = 1'b1; m_frames = 0;
            end
        end else if (m_st == 2) begin
            if (t) begin
                m_frames++;
                if (m_frames == DF) begin
                    if (m_lives == 0) ns = 4;
                    else begin ns = 0; m_fr = 1'b1; end
                end
            end
        end else if (m_st == 3) begin
            if (t) begin
                m_frames++;
                if (m_frames == LF) begin ns = 1; m_fr = 1'b1; end
            end
        end else if (m_st == 4) begin
            if (rise) begin
                ns = 0; m_lives = NL; m_fr = 1'b1; m_rl = 1'b1; m_fresh = 1'b1;
            end
        end
        m_st = ns;
    endtask

    function automatic logic [NL-1:0] exp_lives();
        int  th;
        bit  on;
        th = (1 << m_lives) - 1;
        on = ((m_bticks / BF) % 2) == 0;
        if (m_st == 2) return on ? NL'(th) : '0;
        if (m_st == 4) return on ? ((m_lives == 0) ? {NL{1'b1}} : NL'(th)) : '0;
        return NL'(th);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
    endtask

    task automatic check_all();
        chk("state",  32'(o_State),        32'(m_st));
        chk("active", 32'(o_Game_Active),  32'(m_st == 1));
        chk("over",   32'(o_Game_Over),    32'(m_st == 4));
        chk("frog",   32'(o_Frog_Reset),   32'(m_fr));
        chk("rev",    32'(o_Reverse_Load), 32'(m_rl));
        chk("lives",  32'(o_Lives),        32'(exp_lives()));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cyc(bit s, bit c, bit l, bit t);
        i_Start = s; i_Has_Collided = c; i_Level_Up = l; i_Frame_Tick = t;
        @(posedge i_Clk);
        model_step(s, c, l, t);
        #1;
        check_all();
    endtask

    // n frame ticks, each preceded by a non-tick cycle carrying collision/level-up noise.
    task automatic ticks(int n, bit c, bit l);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, c, l, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        bit rs;
        model_reset();
        i_Rst = 1'b1;
        #12;
        check_all();
        chk("rst_lives", 32'(o_Lives), 32'hF);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        #4;

        step = "start_held";
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                chk("first_active", 32'(o_Game_Active), 32'd1);
                chk("first_rev", 32'(o_Reverse_Load), 32'd1);
            end
        end
        chk("held_still_running", 32'(o_State), 32'd1);
        chk("held_rev_once", 32'(o_Reverse_Load), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        step = "first_death";
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lives_0111", 32'(o_Lives), 32'h7);
        ticks(BF, 1'b1, 1'b1);
        chk("blink_off", 32'(o_Lives), 32'h0);
        ticks(DF - BF, 1'b0, 1'b0);
        chk("respawn_pulse", 32'(o_Frog_Reset), 32'd1);
        chk("respawn_idle", 32'(o_State), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        step = "coll_and_level";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_no_rev", 32'(o_Reverse_Load), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("both_death", 32'(o_State), 32'd2);
        chk("both_no_rev", 32'(o_Reverse_Load), 32'd0);
        chk("both_lives", 32'(o_Lives), 32'h3);
        ticks(DF, 1'b0, 1'b0);

        step = "level_pause";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_state", 32'(o_State), 32'd3);
        chk("pause_inactive", 32'(o_Game_Active), 32'd0);
        chk("pause_rev", 32'(o_Reverse_Load), 32'd1);
        ticks(LF, 1'b1, 1'b1);
        chk("pause_end_run", 32'(o_State), 32'd1);
        chk("pause_end_frog", 32'(o_Frog_Reset), 32'd1);
        chk("pause_lives", 32'(o_Lives), 32'h3);

        step = "to_game_over";
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(DF, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("last_life", 32'(o_Lives), 32'h0);
        ticks(DF, 1'b0, 1'b0);
        chk("go_state", 32'(o_State), 32'd4);
        chk("go_flag", 32'(o_Game_Over), 32'd1);
        ticks(4, 1'b0, 1'b0);
        chk("go_flash_on", 32'(o_Lives), 32'hF);
        ticks(BF, 1'b0, 1'b0);
        chk("go_flash_off", 32'(o_Lives), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("go_restart_idle", 32'(o_State), 32'd0);
        chk("go_restart_lives", 32'(o_Lives), 32'hF);
        chk("go_restart_frog", 32'(o_Frog_Reset), 32'd1);
        chk("go_restart_rev", 32'(o_Reverse_Load), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        step = "reset_mid_death";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(20, 1'b0, 1'b0);
        i_Rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge i_Clk);
        #1;
        check_all();
        chk("rst_state", 32'(o_State), 32'd0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        #4;

        step = "random";
        rs = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) rs = ~rs;
            cyc(rs, $urandom_range(39) == 0, $urandom_range(29) == 0, $urandom_range(2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
